mmio_store_buffer: RTL and testbench
====================================

// Module: mmio_store_buffer
// PURPOSE
//  Downstream consumer of the core's data-memory write bus (MemWrite/DataAdr/WriteData).
//  Captures aligned stores that fall in a memory-mapped I/O window into a FIFO.
//  Drains them to a slower peripheral port over a valid/ready handshake.
//  Exposes full/empty/count and a sticky overflow flag for stores dropped while full.
// PARAMETERS
//  DEPTH  4             FIFO entries; power of two, >= 2
//  AW     32            address width
//  DW     32            data width
//  BASE   32'h0000_0060 first byte address of the MMIO window (inclusive)
//  LIMIT  32'h0000_0080 end of the MMIO window (exclusive); BASE < LIMIT
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              asynchronous, active-high reset
//  MemWrite     in   1              core store strobe, one store per cycle it is high
//  DataAdr      in   AW             core store byte address
//  WriteData    in   DW             core store data
//  out_valid    out  1              head entry is available
//  out_ready    in   1              peripheral accepts the head entry
//  out_addr     out  AW             head entry address
//  out_data     out  DW             head entry data
//  full         out  1              count == DEPTH
//  empty        out  1              count == 0
//  count        out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow     out  1              sticky: an in-window store was dropped
//  clr_overflow in   1              synchronous clear of overflow
// BEHAVIOUR
//  - Reset (async assert): wr_ptr = rd_ptr = 0, count = 0, overflow = 0, out_valid = 0.
//    Storage is not reset. out_addr/out_data are forced to 0 while empty.
//    Operation resumes on the first rising edge after reset deasserts.
//  - hit  = MemWrite && DataAdr >= BASE && DataAdr < LIMIT && DataAdr[1:0] == 2'b00.
//    Misaligned or out-of-window stores are ignored: no state change.
//  - pop  = out_valid && out_ready.
//  - push = hit && (!full || pop).
//  - Push writes {DataAdr, WriteData} at wr_ptr on the rising edge; wr_ptr += 1 modulo DEPTH.
//  - Pop advances rd_ptr += 1 modulo DEPTH on the rising edge. Pointers wrap naturally.
//  - count' = count + push - pop. Push and pop in the same cycle leaves count unchanged.
//    This includes the full and the count==1 cases.
//  - First-word fall-through: out_valid = !empty (registered state). out_addr/out_data = head entry.
//    Latency: a store pushed at edge N into an empty FIFO is visible with out_valid=1 after edge N.
//    There is no same-cycle bypass. Pop while empty is impossible (out_valid=0).
//  - Hold rule: while out_valid && !out_ready, out_addr/out_data stay stable.
//  - Ordering: strict FIFO order; no merging of stores to the same address.
//  - Drop: hit && full && !pop -> store discarded and overflow set to 1 at the edge.
//  - clr_overflow clears overflow at the edge. If a drop occurs in the same cycle, set wins.
//  - full and empty are derived combinationally from count; never both 1.
// TESTING
//  1 Reset mid-operation: fill 3 entries, assert reset -> count=0, empty=1, out_valid=0, overflow=0 immediately.
//  2 Single store: MemWrite, DataAdr=0x60, WriteData=7, out_ready=0 -> next cycle out_valid=1,
//    out_addr=0x60, out_data=7, count=1; with out_ready=1 one cycle -> empty=1.
//  3 Filter: stores to 0x5C, 0x80, 0x62 -> none captured, count stays 0; store to 0x7C -> captured.
//  4 Fill/overflow: 5 stores to 0x64 (data 1..5), out_ready=0 -> full=1 after 4th, 5th dropped,
//    overflow=1; drain returns 1,2,3,4 in order; clr_overflow -> overflow=0.
//  5 Full push+pop: full, store data 9 with out_ready=1 -> count stays 4, no overflow,
//    9 emerges last after wrap-around of both pointers.
//  6 Clear vs drop: full, out_ready=0, in-window store with clr_overflow=1 -> overflow remains 1.

Source files
------------

// File: rtl/mmio_store_buffer.sv
// MMIO store buffer: captures aligned core stores that land in [BASE, LIMIT)
// and drains them in order to a peripheral over a valid/ready handshake.
module mmio_store_buffer #(
    parameter int unsigned    DEPTH = 4,
    parameter int unsigned    AW    = 32,
    parameter int unsigned    DW    = 32,
    parameter logic [AW-1:0]  BASE  = 32'h0000_0060,
    parameter logic [AW-1:0]  LIMIT = 32'h0000_0080
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_addr,
    output logic [DW-1:0]            out_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic hit;
    logic pop;
    logic push;
    logic drop;

    assign hit  = MemWrite && (DataAdr >= BASE) && (DataAdr < LIMIT)
                  && (DataAdr[1:0] == 2'b00);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty;
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    assign out_addr = empty ? '0 : addr_mem[rd_ptr];
    assign out_data = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= DataAdr;
            data_mem[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Self-checking bench for mmio_store_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_mmio_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_overflow;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [63:0] q[$];
    bit          movf;

    mmio_store_buffer #(
        .DEPTH(4), .AW(32), .DW(32), .BASE(32'h0000_0060), .LIMIT(32'h0000_0080)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'h0;
        chk({tag, ".count"},     64'(count),     64'(q.size()));
        chk({tag, ".empty"},     64'(empty),     64'(q.size() == 0));
        chk({tag, ".full"},      64'(full),      64'(q.size() == 4));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".overflow"},  64'(overflow),  64'(movf));
        chk({tag, ".out_addr"},  64'(out_addr),  64'(head[63:32]));
        chk({tag, ".out_data"},  64'(out_data),  64'(head[31:0]));
    endtask

    // One clock: apply inputs, advance the model from its pre-edge state, check after the edge.
    task automatic cycle(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic rdy, input logic clr);
        bit hit, pop, push, drop;
        MemWrite = we; DataAdr = adr; WriteData = dat; out_ready = rdy; clr_overflow = clr;
        hit  = we && adr >= 32'h60 && adr < 32'h80 && adr[1:0] == 2'b00;
        pop  = rdy && q.size() != 0;
        push = hit && (q.size() < 4 || pop);
        drop = hit && !push;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({adr, dat});
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        MemWrite = 1'b0; DataAdr = '0; WriteData = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    initial begin
        logic [31:0] last;
        idle();
        reset = 1'b1;
        q.delete();
        movf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cycle("t1fill", 1'b1, 32'h60 + 32'(4 * i), 32'(i + 10), 1'b0, 1'b0);
        idle();
        #2 reset = 1'b1;
        q.delete();
        movf = 1'b0;
        #1 check_all("t1rst");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single store, then one pop
        cycle("t2push", 1'b1, 32'h60, 32'd7, 1'b0, 1'b0);
        chk("t2.addr", 64'(out_addr), 64'h60);
        chk("t2.data", 64'(out_data), 64'd7);
        cycle("t2pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t2.empty", 64'(empty), 64'd1);

        // Address filter
        cycle("t3lo",  1'b1, 32'h5C, 32'h11, 1'b0, 1'b0);
        cycle("t3hi",  1'b1, 32'h80, 32'h22, 1'b0, 1'b0);
        cycle("t3mis", 1'b1, 32'h62, 32'h33, 1'b0, 1'b0);
        chk("t3.count0", 64'(count), 64'd0);
        cycle("t3top", 1'b1, 32'h7C, 32'h44, 1'b0, 1'b0);
        chk("t3.count1", 64'(count), 64'd1);
        cycle("t3drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill, overflow, ordered drain, clear
        for (int i = 1; i <= 5; i++) begin
            cycle("t4fill", 1'b1, 32'h64, 32'(i), 1'b0, 1'b0);
            if (i == 4) chk("t4.full", 64'(full), 64'd1);
        end
        chk("t4.ovf", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t4.order", 64'(out_data), 64'(i));
            cycle("t4drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        cycle("t4clr", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t4.clr", 64'(overflow), 64'd0);

        // Push and pop while full
        for (int i = 1; i <= 4; i++) cycle("t5fill", 1'b1, 32'h60 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
        cycle("t5pp", 1'b1, 32'h70, 32'd9, 1'b1, 1'b0);
        chk("t5.count", 64'(count), 64'd4);
        chk("t5.ovf", 64'(overflow), 64'd0);
        last = '0;
        for (int i = 0; i < 4; i++) begin
            last = out_data;
            cycle("t5drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("t5.last", 64'(last), 64'd9);

        // Clear and drop in the same cycle
        for (int i = 0; i < 4; i++) cycle("t6fill", 1'b1, 32'h68, 32'(i + 20), 1'b0, 1'b0);
        cycle("t6drop", 1'b1, 32'h68, 32'd5, 1'b0, 1'b1);
        chk("t6.ovf", 64'(overflow), 64'd1);
        cycle("t6clr", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle("t6drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 32'($urandom_range(32'h50, 32'h88)),
                  $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
